ir_transmitter: RTL and testbench
=================================

IR_TRANSMITTER -- requirements
Module: ir_transmitter

Interface
REQ-001 Parameters SHALL be, one per line (all timings in clk_in cycles, each legal value ≥1):
  SBD  900  sync burst duration
  SSD  450  sync silence duration
  BBD  60   bit burst duration
  BSD0 60   bit silence duration for a 0
  BSD1 160  bit silence duration for a 1
  GAP  500  idle-high guard after the final burst
  CARRIER_HALF  2  carrier half-period; used only under IR_CARRIER_EN
REQ-002 Ports SHALL be, one per line:
  clk_in  input  1  system clock
  rst_in  input  1  asynchronous, active-high reset
  code_in  input  32  code to transmit, MSB first
  valid_in  input  1  request to send code_in
  ready_out  output  1  high when a request can be accepted
  signal_out  output  1  demodulated IR line: 0 = burst, 1 = silence/idle
  done_out  output  1  one-cycle pulse at the end of a frame
  state_out  output  3  current FSM state encoding
REQ-003 The block SHALL use one clock, clk_in; rst_in SHALL be asynchronous and active-high.

Function
REQ-004 The FSM SHALL use these states and encodings: IDLE=0, SYNC_BURST=1, SYNC_SILENCE=2, BIT_BURST=3, BIT_SILENCE=4, FINAL_BURST=5, GAP=6.
REQ-005 ready_out SHALL be 1 only in IDLE.
REQ-006 On a rising edge with valid_in=1 and ready_out=1, the block SHALL latch code_in into a shift register, clear the bit counter and enter SYNC_BURST.
REQ-007 valid_in outside IDLE SHALL be ignored; requests SHALL NOT be queued.
REQ-008 signal_out SHALL be 0 in SYNC_BURST, BIT_BURST and FINAL_BURST, and 1 in every other state; it SHALL be driven from a register so it is glitch-free.
REQ-009 Each state SHALL last exactly its parameter count in cycles: SYNC_BURST=SBD, SYNC_SILENCE=SSD, BIT_BURST=BBD, BIT_SILENCE=BSD1 if the current bit is 1 else BSD0, FINAL_BURST=BBD, GAP=GAP.
REQ-010 Transitions SHALL be SYNC_BURST->SYNC_SILENCE->BIT_BURST; BIT_SILENCE->BIT_BURST while bits sent <32; after the 32nd BIT_SILENCE ->FINAL_BURST->GAP->IDLE.
REQ-011 The shift register SHALL shift left by one at the end of each BIT_SILENCE; the current bit SHALL be its bit 31.
REQ-012 signal_out SHALL go to 0 on the cycle after acceptance; total frame length from acceptance to done_out SHALL be SBD+SSD+33*BBD+n1*BSD1+(32-n1)*BSD0+GAP cycles, where n1 is the popcount of the code.
REQ-013 done_out SHALL pulse high for exactly one cycle, on the last GAP cycle; ready_out SHALL rise on the following cycle.
REQ-014 Back-to-back frames SHALL be supported: valid_in held high SHALL start the next SYNC_BURST the cycle after ready_out rises.
REQ-015 The duration counter SHALL be $clog2(max parameter + 1) bits wide, SHALL reload on every state entry and SHALL never wrap.
REQ-016 The bit counter SHALL be 6 bits wide and SHALL count 0..32.

Reset
REQ-017 Reset SHALL force state IDLE, signal_out=1, ready_out=1, done_out=0, state_out=0, and clear all counters and the shift register.
REQ-018 Reset asserted mid-frame SHALL return signal_out to 1 immediately (asynchronously); no done_out pulse SHALL be produced for the aborted frame.

Configuration
REQ-019 Macro IR_CARRIER_EN: when defined, the block SHALL add port led_out (output, 1 bit); during the burst states led_out SHALL toggle every CARRIER_HALF cycles, starting high on the first burst cycle with the carrier phase restarted at each burst; outside bursts and under reset led_out SHALL be 0.
REQ-020 When IR_CARRIER_EN is not defined, led_out and the carrier counter SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-021 Reset, then send 0x19861989 -> signal_out low for 900 cycles, high for 450, 32 bit cells, final 60-cycle low; done_out pulses 6950 cycles after acceptance.
REQ-022 Loopback into ir_decoder with the same parameters, codes 0xABCD1234, 0x00000000 and 0xFFFFFFFF -> decoder new_code_out pulses with a matching code_out and error_out=0.
REQ-023 Pulse valid_in mid-frame with 0xDEADBEEF -> ignored; the current frame completes unchanged and ready_out stays 0 until after done_out.
REQ-024 Assert rst_in during bit 10 -> signal_out=1 within the same cycle, state_out=0, no done_out; a later 0x12345678 frame transmits correctly.
REQ-025 Hold valid_in high for two frames -> the second SYNC_BURST begins exactly 1 cycle after ready_out rises, with no gap beyond GAP.
REQ-026 With IR_CARRIER_EN and CARRIER_HALF=2 -> led_out pattern 1,1,0,0,... during each burst and 0 during silences.

Source files
------------

// File: rtl/ir_transmitter.sv
// IR frame transmitter: sync burst/silence, 32 pulse-distance bits MSB first, final burst, idle guard.
// Optional 38 kHz-style carrier output led_out is enabled by defining IR_CARRIER_EN.
module ir_transmitter #(
   parameter int unsigned SBD          = 900,
   parameter int unsigned SSD          = 450,
   parameter int unsigned BBD          = 60,
   parameter int unsigned BSD0         = 60,
   parameter int unsigned BSD1         = 160,
   parameter int unsigned GAP          = 500,
   parameter int unsigned CARRIER_HALF = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] code_in,
   input  logic        valid_in,
   output logic        ready_out,
   output logic        signal_out,
   output logic        done_out,
   output logic [2:0]  state_out
`ifdef IR_CARRIER_EN
   ,
   output logic        led_out
`endif
);

   localparam int unsigned MAX_A  = (SBD > SSD) ? SBD : SSD;
   localparam int unsigned MAX_B  = (BBD > BSD0) ? BBD : BSD0;
   localparam int unsigned MAX_C  = (BSD1 > GAP) ? BSD1 : GAP;
   localparam int unsigned MAX_AB = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned MAX_P  = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
   localparam int unsigned CW     = $clog2(MAX_P + 1);
   localparam int unsigned NBITS  = 32;

   // Every duration must be at least one cycle
   if (SBD == 0 || SSD == 0 || BBD == 0 || BSD0 == 0 || BSD1 == 0 || GAP == 0 ||
       CARRIER_HALF == 0) begin : g_bad_params
      $error("ir_transmitter: all timing parameters must be >= 1");
   end

   typedef enum logic [2:0] {
      ST_IDLE         = 3'd0,
      ST_SYNC_BURST   = 3'd1,
      ST_SYNC_SILENCE = 3'd2,
      ST_BIT_BURST    = 3'd3,
      ST_BIT_SILENCE  = 3'd4,
      ST_FINAL_BURST  = 3'd5,
      ST_GAP          = 3'd6
   } state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  cnt, cnt_nxt;
   logic [5:0]     bits, bits_nxt;
   logic [31:0]    shreg, shreg_nxt;
   logic           burst_nxt;
   logic           ready_nxt;
   logic           done_nxt;

   // State, counters and registered outputs
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         bits       <= '0;
         shreg      <= '0;
         ready_out  <= 1'b1;
         signal_out <= 1'b1;
         done_out   <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         bits       <= bits_nxt;
         shreg      <= shreg_nxt;
         ready_out  <= ready_nxt;
         signal_out <= ~burst_nxt;
         done_out   <= done_nxt;
      end
   end

   // Next state: the duration counter is loaded with (duration-1) on entry and
   // the state is left when it reads zero, so it never wraps.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      bits_nxt  = bits;
      shreg_nxt = shreg;

      if (state == ST_IDLE) begin
         if (valid_in) begin
            shreg_nxt = code_in;
            bits_nxt  = '0;
            cnt_nxt   = CW'(SBD - 1);
            state_nxt = ST_SYNC_BURST;
         end
      end else if (cnt != '0) begin
         cnt_nxt = cnt - CW'(1);
      end else begin
         case (state)
            ST_SYNC_BURST: begin
               state_nxt = ST_SYNC_SILENCE;
               cnt_nxt   = CW'(SSD - 1);
            end
            ST_SYNC_SILENCE: begin
               state_nxt = ST_BIT_BURST;
               cnt_nxt   = CW'(BBD - 1);
            end
            ST_BIT_BURST: begin
               state_nxt = ST_BIT_SILENCE;
               cnt_nxt   = shreg[31] ? CW'(BSD1 - 1) : CW'(BSD0 - 1);
            end
            ST_BIT_SILENCE: begin
               shreg_nxt = {shreg[30:0], 1'b0};
               bits_nxt  = bits + 6'd1;
               cnt_nxt   = CW'(BBD - 1);
               state_nxt = (bits == 6'(NBITS - 1)) ? ST_FINAL_BURST : ST_BIT_BURST;
            end
            ST_FINAL_BURST: begin
               state_nxt = ST_GAP;
               cnt_nxt   = CW'(GAP - 1);
            end
            ST_GAP: begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end
            default: begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end

      burst_nxt = (state_nxt == ST_SYNC_BURST) || (state_nxt == ST_BIT_BURST) ||
                  (state_nxt == ST_FINAL_BURST);
      ready_nxt = (state_nxt == ST_IDLE);
      done_nxt  = (state_nxt == ST_GAP) && (cnt_nxt == '0);
   end

   assign state_out = state;

`ifdef IR_CARRIER_EN
   localparam int unsigned CCW = $clog2(CARRIER_HALF + 1);

   logic [CCW-1:0] ccnt;
   logic           in_burst;

   assign in_burst = (state == ST_SYNC_BURST) || (state == ST_BIT_BURST) ||
                     (state == ST_FINAL_BURST);

   // Carrier restarts high at every burst entry; bursts are never adjacent
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         led_out <= 1'b0;
         ccnt    <= '0;
      end else if (!burst_nxt) begin
         led_out <= 1'b0;
         ccnt    <= '0;
      end else if (!in_burst || ccnt == '0) begin
         led_out <= in_burst ? ~led_out : 1'b1;
         ccnt    <= CCW'(CARRIER_HALF - 1);
      end else begin
         ccnt    <= ccnt - CCW'(1);
      end
   end
`endif

endmodule

// File: tb/tb_ir_transmitter.sv
// Directed self-checking bench for ir_transmitter: decodes signal_out pulse widths back
// into a code and checks frame timing, handshake, mid-frame ignore, reset abort, back-to-back.
module tb_ir_transmitter;

   localparam int unsigned SBD  = 900;
   localparam int unsigned SSD  = 450;
   localparam int unsigned BBD  = 60;
   localparam int unsigned BSD0 = 60;
   localparam int unsigned BSD1 = 160;
   localparam int unsigned GAP  = 500;
   localparam int unsigned CH   = 2;
   localparam int          BUDGET = 20000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] code_in = '0;
   logic        valid_in = 1'b0;
   logic        ready_out, signal_out, done_out;
   logic [2:0]  state_out;
`ifdef IR_CARRIER_EN
   logic        led_out;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   int done_pulses = 0;
   int last_wait;
   int runs[$];

   ir_transmitter #(
      .SBD(SBD), .SSD(SSD), .BBD(BBD), .BSD0(BSD0), .BSD1(BSD1), .GAP(GAP), .CARRIER_HALF(CH)
   ) dut (
      .clk_in(clk), .rst_in(rst), .code_in(code_in), .valid_in(valid_in),
      .ready_out(ready_out), .signal_out(signal_out), .done_out(done_out),
      .state_out(state_out)
`ifdef IR_CARRIER_EN
      , .led_out(led_out)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done_out) done_pulses++;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int frame_len(input logic [31:0] code);
      int n1 = $countones(code);
      return SBD + SSD + 33 * BBD + n1 * BSD1 + (32 - n1) * BSD0 + GAP;
   endfunction

   // Send one frame and decode the waveform; hold keeps valid_in high afterwards
   task automatic send_frame(input logic [31:0] code, input bit hold, input bit inject,
                             input string tag);
      int len = 0;
      int ready_hi = 0;
      int bad_cells = 0;
      int led_err = 0;
      logic lvl = 1'b1;
      logic [31:0] got = '0;
      last_wait = 0;
      while (!ready_out && last_wait < BUDGET) begin
         tick();
         last_wait++;
      end
      code_in  = code;
      valid_in = 1'b1;
      tick();
      if (!hold) valid_in = 1'b0;
      chk({tag, "_state_c1"}, 32'(state_out), 32'd1);
      chk({tag, "_sig_c1"}, 32'(signal_out), 32'd0);
      runs.delete();
      for (int cyc = 1; cyc <= BUDGET; cyc++) begin
         if (runs.size() == 0 || signal_out !== lvl) begin
            runs.push_back(1);
            lvl = signal_out;
         end else begin
            runs[runs.size() - 1] = runs[runs.size() - 1] + 1;
         end
         if (ready_out) ready_hi++;
`ifdef IR_CARRIER_EN
         if (led_out !== ((lvl == 1'b0) ? (((runs[runs.size() - 1] - 1) / CH) % 2 == 0)
                                        : 1'b0)) led_err++;
`endif
         if (inject && cyc == 2000) begin
            code_in  = 32'hDEADBEEF;
            valid_in = 1'b1;
         end else if (inject && cyc == 2001) begin
            valid_in = 1'b0;
         end
         if (done_out) begin
            len = cyc;
            break;
         end
         tick();
      end
      chk({tag, "_len"}, 32'(len), 32'(frame_len(code)));
      chk({tag, "_nruns"}, 32'(runs.size()), 32'd68);
      if (runs.size() == 68) begin
         for (int k = 0; k < 32; k++) begin
            if (runs[2 + 2 * k] != int'(BBD)) bad_cells++;
            if (runs[3 + 2 * k] == int'(BSD1)) got[31 - k] = 1'b1;
            else if (runs[3 + 2 * k] != int'(BSD0)) bad_cells++;
         end
         chk({tag, "_sync_lo"}, 32'(runs[0]), 32'(SBD));
         chk({tag, "_sync_hi"}, 32'(runs[1]), 32'(SSD));
         chk({tag, "_final_lo"}, 32'(runs[66]), 32'(BBD));
         chk({tag, "_gap"}, 32'(runs[67]), 32'(GAP));
      end
      chk({tag, "_bad_cells"}, 32'(bad_cells), 32'd0);
      chk({tag, "_code"}, got, code);
      chk({tag, "_ready_busy"}, 32'(ready_hi), 32'd0);
`ifdef IR_CARRIER_EN
      chk({tag, "_led"}, 32'(led_err), 32'd0);
`endif
      tick();
      chk({tag, "_ready_after"}, 32'(ready_out), 32'd1);
      chk({tag, "_state_after"}, 32'(state_out), 32'd0);
      chk({tag, "_done_after"}, 32'(done_out), 32'd0);
   endtask

   initial begin
      int bursts;
      logic [2:0] prev_state;

      // Reset values
      tick();
      tick();
      chk("rst_ready", 32'(ready_out), 32'd1);
      chk("rst_signal", 32'(signal_out), 32'd1);
      chk("rst_done", 32'(done_out), 32'd0);
      chk("rst_state", 32'(state_out), 32'd0);
      rst = 1'b0;
      tick();

      // Reference frame with hand-computed length
      chk("ref_len_model", 32'(frame_len(32'h19861989)), 32'd6950);
      send_frame(32'h19861989, 1'b0, 1'b0, "f19861989");

      // Loopback-style decode of mixed, all-zero and all-one codes
      send_frame(32'hABCD1234, 1'b0, 1'b0, "fABCD1234");
      send_frame(32'h00000000, 1'b0, 1'b0, "f00000000");
      send_frame(32'hFFFFFFFF, 1'b0, 1'b0, "fFFFFFFFF");

      // Request during a frame is ignored
      send_frame(32'h13579BDF, 1'b0, 1'b1, "finject");
      chk("done_count_a", 32'(done_pulses), 32'd5);

      // Abort during bit 10
      code_in  = 32'hA5A5A5A5;
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      bursts = 0;
      prev_state = state_out;
      for (int i = 0; i < BUDGET && bursts < 11; i++) begin
         tick();
         if (state_out == 3'd3 && prev_state != 3'd3) bursts++;
         prev_state = state_out;
      end
      chk("abort_reached_bit10", 32'(bursts), 32'd11);
      repeat (5) tick();
      chk("abort_pre_sig", 32'(signal_out), 32'd0);
      #1 rst = 1'b1;
      #1;
      chk("abort_sig", 32'(signal_out), 32'd1);
      chk("abort_state", 32'(state_out), 32'd0);
      chk("abort_ready", 32'(ready_out), 32'd1);
      tick();
      tick();
      rst = 1'b0;
      repeat (20) tick();
      chk("abort_no_done", 32'(done_pulses), 32'd5);

      send_frame(32'h12345678, 1'b0, 1'b0, "f12345678");

      // Back-to-back with valid held high
      send_frame(32'h0F0F3C3C, 1'b1, 1'b0, "b2b_1");
      send_frame(32'h0F0F3C3C, 1'b0, 1'b0, "b2b_2");
      chk("b2b_wait", 32'(last_wait), 32'd0);
      chk("done_count_b", 32'(done_pulses), 32'd8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
